// File: rtl/uart_sample_framer.sv
// Buffers I2S samples in a FIFO and sends each one to a byte-wide UART as
// a frame: sync byte, sample bytes MSB first, then the XOR of the sample bytes.
module uart_sample_framer #(
    parameter int          SAMPLE_WIDTH = 24,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [SAMPLE_WIDTH-1:0]       sample_in,
    input  logic                          sample_valid_in,
    input  logic                          tx_busy_in,
    output logic [7:0]                    tx_data_out,
    output logic                          tx_trigger_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic [7:0]                    overflow_count_out
);

    localparam int NB = SAMPLE_WIDTH / 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(NB + 2);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, WAIT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [SAMPLE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [LW-1:0]           r_level;
    logic [7:0]              r_ovf_cnt;

    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [7:0]              r_csum;
    logic [IW-1:0]           r_idx;
    logic [7:0]              r_tx_data;
    logic                    r_tx_trig;

    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_drop;
    logic [SAMPLE_WIDTH-1:0] w_head;
    logic [7:0]              w_head_csum;
    logic                    w_trig_nxt;
    logic                    w_idx_adv;
    logic [7:0]              w_cur_byte;

    // A pop in the same cycle frees a slot, so a strobe while full is still accepted.
    assign w_full = (r_level == LW'(FIFO_DEPTH));
    assign w_pop  = (r_state == IDLE) && (r_level != '0);
    assign w_push = sample_valid_in && (!w_full || w_pop);
    assign w_drop = sample_valid_in && w_full && !w_pop;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_head_csum = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_head_csum = w_head_csum ^ w_head[i*8 +: 8];
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LW'(1);
            end
            if (w_drop && (r_ovf_cnt != '1)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_pop)       w_state_nxt = SEND;
            SEND: if (!tx_busy_in) w_state_nxt = GAP;
            GAP:                   w_state_nxt = WAIT;
            WAIT: if (!tx_busy_in) w_state_nxt = (r_idx == LAST_IDX) ? IDLE : SEND;
            default:               w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_trig_nxt = (r_state == SEND) && !tx_busy_in;
        w_idx_adv  = (r_state == WAIT) && !tx_busy_in && (r_idx != LAST_IDX);
        if (r_idx == '0) begin
            w_cur_byte = SYNC_BYTE;
        end else if (r_idx == LAST_IDX) begin
            w_cur_byte = r_csum;
        end else begin
            w_cur_byte = r_shift[SAMPLE_WIDTH-1 -: 8];
        end
    end

    // Sample bytes leave from the top of the shift register, one shift per byte sent.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_shift   <= '0;
            r_csum    <= '0;
            r_idx     <= '0;
            r_tx_data <= '0;
            r_tx_trig <= 1'b0;
        end else begin
            r_tx_trig <= w_trig_nxt;
            if (w_pop) begin
                r_shift <= w_head;
                r_csum  <= w_head_csum;
                r_idx   <= '0;
            end else if (w_idx_adv) begin
                r_idx <= r_idx + IW'(1);
            end
            if (w_trig_nxt) begin
                r_tx_data <= w_cur_byte;
                if ((r_idx != '0) && (r_idx != LAST_IDX)) begin
                    r_shift <= r_shift << 8;
                end
            end
        end
    end

    assign tx_data_out        = r_tx_data;
    assign tx_trigger_out     = r_tx_trig;
    assign fifo_level_out     = r_level;
    assign overflow_count_out = r_ovf_cnt;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Directed bench for uart_sample_framer: frame contents, latency, FIFO overflow
// and saturation, full-FIFO push with simultaneous pop, and reset mid-frame.
module tb_uart_sample_framer;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [23:0] sample_in;
    logic        sample_valid_in;
    logic        tx_busy_in;
    logic [7:0]  tx_data_out;
    logic        tx_trigger_out;
    logic [4:0]  fifo_level_out;
    logic [7:0]  overflow_count_out;

    int          n_checks = 0;
    int          n_errors = 0;

    logic        model_en;
    logic        busy_drv;
    int          busy_cnt = 0;
    logic [7:0]  q[$];
    logic        prev_trig = 1'b0;

    uart_sample_framer #(
        .SAMPLE_WIDTH (24),
        .FIFO_DEPTH   (16),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .sample_in          (sample_in),
        .sample_valid_in    (sample_valid_in),
        .tx_busy_in         (tx_busy_in),
        .tx_data_out        (tx_data_out),
        .tx_trigger_out     (tx_trigger_out),
        .fifo_level_out     (fifo_level_out),
        .overflow_count_out (overflow_count_out)
    );

    always #5 clk_in = ~clk_in;

    // UART model: busy for 10 cycles after each trigger, or driven directly.
    assign tx_busy_in = model_en ? (busy_cnt != 0) : busy_drv;

    always @(posedge clk_in) begin
        if (tx_trigger_out)    busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (tx_trigger_out) begin
            check("trig_one_cycle", 32'(prev_trig), 32'd0);
            q.push_back(tx_data_out);
        end
        prev_trig <= tx_trigger_out;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic strobe(input logic [23:0] s);
        sample_in       = s;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        sample_valid_in = 1'b0;
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        tick();
        q.delete();
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k = 0;
        while (q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(q.size() >= n), 32'd1);
    endtask

    task automatic wait_trig(input string tag, input int budget);
        int k = 0;
        while (!tx_trigger_out && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(tx_trigger_out), 32'd1);
    endtask

    task automatic expect5(input string tag, input logic [39:0] exp);
        logic [7:0] b;
        check($sformatf("%s_avail", tag), 32'(q.size() >= 5), 32'd1);
        if (q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                b = q.pop_front();
                check($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp[39-8*i -: 8]));
            end
        end
    endtask

    function automatic logic [39:0] exp_frame(input logic [23:0] s);
        return {8'hA5, s, s[23:16] ^ s[15:8] ^ s[7:0]};
    endfunction

    function automatic logic [23:0] ov_sample(input int k);
        logic [7:0] kk;
        kk = 8'(k);
        return {8'h10 + kk, 8'h80 + kk, 8'h3C ^ kk};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in          = 1'b1;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        model_en        = 1'b1;
        busy_drv        = 1'b0;
        repeat (3) tick();
        check("rst_level", 32'(fifo_level_out), 32'd0);
        check("rst_ovf", 32'(overflow_count_out), 32'd0);
        check("rst_data", 32'(tx_data_out), 32'd0);
        check("rst_trig", 32'(tx_trigger_out), 32'd0);
        rst_in = 1'b0;
        tick();
        q.delete();

        // Single sample: latency and frame contents.
        sample_in       = 24'h123456;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        check("lat_level_t0", 32'(fifo_level_out), 32'd1);
        check("lat_trig_t0", 32'(tx_trigger_out), 32'd0);
        tick();
        check("lat_trig_t1", 32'(tx_trigger_out), 32'd0);
        check("lat_level_t1", 32'(fifo_level_out), 32'd0);
        tick();
        check("lat_trig_t2", 32'(tx_trigger_out), 32'd1);
        check("lat_data_t2", 32'(tx_data_out), 32'hA5);
        wait_bytes("single_wait", 5, 200);
        repeat (40) tick();
        check("single_count", 32'(q.size()), 32'd5);
        expect5("single", 40'hA5_12_34_56_70);

        // Checksum vectors, sent back to back.
        strobe(24'hFF00FF);
        strobe(24'h000000);
        wait_bytes("csum_wait", 10, 400);
        repeat (40) tick();
        check("csum_count", 32'(q.size()), 32'd10);
        expect5("csum_ff00ff", 40'hA5_FF_00_FF_00);
        expect5("csum_zero", 40'hA5_00_00_00_00);

        // Overflow with the UART held busy.
        model_en = 1'b0;
        busy_drv = 1'b1;
        do_reset();
        for (int k = 0; k < 20; k++) strobe(ov_sample(k));
        tick();
        check("ovf_level", 32'(fifo_level_out), 32'd16);
        check("ovf_count", 32'(overflow_count_out), 32'd3);
        check("ovf_no_trig", 32'(q.size()), 32'd0);

        // Finish the in-flight frame by hand so the next pop lands on a known edge.
        for (int b = 0; b < 5; b++) begin
            busy_drv = 1'b0;
            wait_trig($sformatf("manual_trig%0d", b), 10);
            busy_drv = 1'b1;
            tick();
        end
        tick();
        check("full_before_pop", 32'(fifo_level_out), 32'd16);
        busy_drv = 1'b0;
        tick();
        sample_in       = 24'hC0FFEE;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
        check("full_pop_level", 32'(fifo_level_out), 32'd16);
        check("full_pop_ovf", 32'(overflow_count_out), 32'd3);
        model_en = 1'b1;
        wait_bytes("order_wait", 90, 3000);
        repeat (40) tick();
        check("order_count", 32'(q.size()), 32'd90);
        for (int k = 0; k < 17; k++) expect5($sformatf("order%0d", k), exp_frame(ov_sample(k)));
        expect5("order_late", exp_frame(24'hC0FFEE));

        // Counter saturation.
        model_en = 1'b0;
        busy_drv = 1'b1;
        do_reset();
        for (int k = 0; k < 271; k++) strobe(24'(k));
        tick();
        check("sat_254", 32'(overflow_count_out), 32'd254);
        strobe(24'h0AAAAA);
        tick();
        check("sat_255", 32'(overflow_count_out), 32'd255);
        for (int k = 0; k < 28; k++) strobe(24'(k));
        tick();
        check("sat_hold", 32'(overflow_count_out), 32'd255);
        check("sat_level", 32'(fifo_level_out), 32'd16);

        // Reset in the middle of a frame.
        busy_drv = 1'b0;
        model_en = 1'b1;
        do_reset();
        repeat (15) tick();
        strobe(24'h445566);
        strobe(24'h778899);
        wait_bytes("mid_first", 1, 100);
        wait_trig("mid_second", 40);
        check("mid_byte2", 32'(tx_data_out), 32'h44);
        rst_in = 1'b1;
        #1;
        check("mid_rst_trig", 32'(tx_trigger_out), 32'd0);
        check("mid_rst_data", 32'(tx_data_out), 32'd0);
        check("mid_rst_level", 32'(fifo_level_out), 32'd0);
        tick();
        tick();
        rst_in = 1'b0;
        q.delete();
        repeat (20) tick();
        check("mid_no_resume", 32'(q.size()), 32'd0);
        strobe(24'hABCDEF);
        wait_bytes("post_rst_wait", 5, 200);
        repeat (40) tick();
        check("post_rst_count", 32'(q.size()), 32'd5);
        expect5("post_rst", 40'hA5_AB_CD_EF_89);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
